// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and a
// constant log2 helper used to size the bit counter.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// Single full-adder cell; the bit-serial adder steps one operand bit
// pair plus the fed-back carry through it each clock.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one
// full-adder cell, with its carry registered back into the cell's carry input.
module serial_adder
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int unsigned CW = clog2(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_sum;
    logic             w_carry;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    serial_adder_fa u_fa (
        .a     (r_a[0]),
        .b     (r_b[0]),
        .c     (r_carry),
        .sum   (w_sum),
        .carry (w_carry)
    );

    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    // Each new sum bit enters at the MSB, so after WIDTH steps bit 0 sits at the LSB.
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE:             w_next = ST_IDLE;
            default:             w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= cin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= w_res_next;
                    r_carry <= w_carry;
                    if (w_last) begin
                        sum_out <= w_res_next;
                        cout    <= w_carry;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes arithmetic expectations
// with their due cycle, a monitor checks busy/done/result every cycle.
module tb_serial_adder;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int unsigned  due;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic [W-1:0] b_in  = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  cyc    = 0;
    exp_t         q[$];
    logic [W-1:0] held_sum  = '0;
    logic         held_cout = 1'b0;
    logic         mon_busy;
    logic         mon_done;

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endfunction

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Called at a falling edge: the next rising edge accepts the operation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] r;
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        r     = ref_add(a, b, c);
        q.push_back('{r[W-1:0], r[W], cyc + 1 + W});
    endtask

    task automatic scramble();
        a_in = W'($urandom);
        b_in = W'($urandom);
        cin  = 1'($urandom);
    endtask

    task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        issue(a, b, c);
        @(negedge clk);
        start = 1'b0;
        scramble();
        repeat (W + 2) @(negedge clk);
    endtask

    // Monitor: one evaluation per rising clock edge and per reset assertion.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (clk) cyc++;
            if (!rst_n) begin
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_done", 32'(done), 32'(0));
                chk("rst_sum",  32'(sum_out), 32'(0));
                chk("rst_cout", 32'(cout), 32'(0));
                q.delete();
                held_sum  = '0;
                held_cout = 1'b0;
            end else begin
                mon_busy = 1'b0;
                mon_done = 1'b0;
                if (q.size() > 0) begin
                    mon_busy = (cyc + W >= q[0].due) && (cyc < q[0].due);
                    mon_done = (cyc == q[0].due);
                end
                chk("busy", 32'(busy), 32'(mon_busy));
                chk("done", 32'(done), 32'(mon_done));
                if (mon_done) begin
                    held_sum  = q[0].sum;
                    held_cout = q[0].cout;
                    void'(q.pop_front());
                end
                chk("sum_out", 32'(sum_out), 32'(held_sum));
                chk("cout",    32'(cout), 32'(held_cout));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        directed(8'h5A, 8'h3C, 1'b0);
        directed(8'hFF, 8'h01, 1'b0);
        directed(8'hFF, 8'hFF, 1'b1);
        directed(8'h00, 8'h00, 1'b0);
        directed(8'h5A, 8'h3C, 1'b0);

        // Extra start pulses during a run must be ignored.
        @(negedge clk);
        issue(8'hA5, 8'h5B, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a_in = 8'h11; b_in = 8'h22; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; a_in = 8'h77; b_in = 8'h66; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // Reset in the middle of a run aborts it without a done pulse.
        @(negedge clk);
        issue(8'hC3, 8'h4E, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        directed(8'h12, 8'h34, 1'b0);

        // Start held high: a new operation every W+2 cycles, inputs churned meanwhile.
        for (int j = 0; j < 1000; j++) begin
            @(negedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom));
            repeat (W + 1) begin
                @(negedge clk);
                scramble();
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
